// File: rtl/link_seq_147_pkg.sv
// rtl/link_seq_147_pkg.sv - shared encodings for the link monitor sequencer
package link_seq_147_pkg;

    // Receive status seen by the link monitor
    localparam logic RCV_OK     = 1'b1;
    localparam logic RCV_NOT_OK = 1'b0;

    // link_status reported by the link monitor
    localparam logic LS_OK   = 1'b0;
    localparam logic LS_FAIL = 1'b1;

    // link_control driven into the link monitor
    localparam logic LC_ENABLE  = 1'b0;
    localparam logic LC_DISABLE = 1'b1;

    // Sequencer state encodings, also exported on seq_state
    localparam logic [2:0] ST_RESET_HOLD = 3'd0;
    localparam logic [2:0] ST_DISABLED   = 3'd1;
    localparam logic [2:0] ST_QUALIFY    = 3'd2;
    localparam logic [2:0] ST_LINK_UP    = 3'd3;
    localparam logic [2:0] ST_FAULT      = 3'd4;

endpackage

// File: rtl/link_seq_147_rcv_qual.sv
// rtl/link_seq_147_rcv_qual.sv - consecutive-ones debouncer for the raw PMA lock
module rcv_qual_147 #(
    parameter int QUAL_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic din,
    output logic qualified
);

    localparam int CW = $clog2(QUAL_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Count consecutive ones, restart on any zero or clear, saturate at QUAL_CYCLES
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || !din) begin
            cnt <= '0;
        end else if (cnt != CW'(QUAL_CYCLES)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fires on the cycle that completes the QUAL_CYCLES-th consecutive one
    assign qualified = !clr && din && (cnt >= CW'(QUAL_CYCLES - 1));

endmodule

// File: rtl/link_seq_147.sv
// rtl/link_seq_147.sv - bring-up sequencer between management and the link monitor
module link_seq_147
    import link_seq_147_pkg::*;
#(
    parameter int RESET_CYCLES = 16,
    parameter int QUAL_CYCLES  = 64,
    parameter int LINK_TIMEOUT = 4096,
    parameter int MAX_RETRIES  = 3,
    parameter int TIMER_W      = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mgmt_enable,
    input  logic       mgmt_restart,
    input  logic       rcv_raw,
    input  logic       link_status,
    output logic       pma_reset,
    output logic       link_control,
    output logic       loc_rcv_status,
    output logic [1:0] retry_cnt,
    output logic       fault,
    output logic [2:0] seq_state
);

    logic [2:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         retry_q, retry_d, retry_inc;
    logic               fault_q, fault_d;
    logic               qual_clr, qualified;

    // The debouncer only runs while qualifying; any other state holds it cleared
    assign qual_clr = (state_q != ST_QUALIFY);

    rcv_qual_147 #(
        .QUAL_CYCLES(QUAL_CYCLES)
    ) u_rcv_qual (
        .clk      (clk),
        .reset    (reset),
        .clr      (qual_clr),
        .din      (rcv_raw),
        .qualified(qualified)
    );

    // Saturating retry increment used on a qualify timeout
    always_comb begin
        retry_inc = (retry_q == 2'(MAX_RETRIES)) ? retry_q : retry_q + 2'd1;
    end

    // Next-state logic: restart beats disable beats the per-state rules
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fault_d = fault_q;
        if (mgmt_restart) begin
            state_d = ST_RESET_HOLD;
        end else if (!mgmt_enable && state_q != ST_RESET_HOLD) begin
            state_d = ST_DISABLED;
            retry_d = 2'd0;
            fault_d = 1'b0;
        end else begin
            case (state_q)
                ST_RESET_HOLD: begin
                    if (timer_q == TIMER_W'(RESET_CYCLES - 1)) begin
                        state_d = mgmt_enable ? ST_QUALIFY : ST_DISABLED;
                    end
                end
                ST_DISABLED: begin
                    if (mgmt_enable) begin
                        state_d = ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    if (qualified) begin
                        state_d = ST_LINK_UP;
                    end else if (timer_q == TIMER_W'(LINK_TIMEOUT - 1)) begin
                        retry_d = retry_inc;
                        if (retry_inc == 2'(MAX_RETRIES)) begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            state_d = ST_RESET_HOLD;
                        end
                    end
                end
                ST_LINK_UP: begin
                    if (link_status == LS_OK) begin
                        retry_d = 2'd0;
                    end
                    if (!rcv_raw) begin
                        state_d = ST_QUALIFY;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_RESET_HOLD;
                end
            endcase
        end
    end

    // Shared timer restarts on every state change or restart request, saturates otherwise
    always_comb begin
        if (mgmt_restart || state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == {TIMER_W{1'b1}}) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    // State, counters and outputs; outputs are registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_RESET_HOLD;
            timer_q        <= '0;
            retry_q        <= 2'd0;
            fault_q        <= 1'b0;
            pma_reset      <= 1'b1;
            link_control   <= LC_DISABLE;
            loc_rcv_status <= RCV_NOT_OK;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            retry_q        <= retry_d;
            fault_q        <= fault_d;
            pma_reset      <= (state_d == ST_RESET_HOLD);
            link_control   <= (state_d == ST_QUALIFY || state_d == ST_LINK_UP) ? LC_ENABLE : LC_DISABLE;
            loc_rcv_status <= (state_d == ST_LINK_UP) ? RCV_OK : RCV_NOT_OK;
        end
    end

    assign retry_cnt = retry_q;
    assign fault     = fault_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_link_seq_147.sv
// tb/tb_link_seq_147.sv - directed vector bench for link_seq_147
module tb_link_seq_147;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mgmt_enable = 1'b0;
    logic       mgmt_restart = 1'b0;
    logic       rcv_raw = 1'b0;
    logic       link_status = 1'b1;
    logic       pma_reset;
    logic       link_control;
    logic       loc_rcv_status;
    logic [1:0] retry_cnt;
    logic       fault;
    logic [2:0] seq_state;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic       en;
        logic       rr;
        logic       raw;
        logic       ls;
        int         cyc;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    link_seq_147 dut (
        .clk           (clk),
        .reset         (reset),
        .mgmt_enable   (mgmt_enable),
        .mgmt_restart  (mgmt_restart),
        .rcv_raw       (rcv_raw),
        .link_status   (link_status),
        .pma_reset     (pma_reset),
        .link_control  (link_control),
        .loc_rcv_status(loc_rcv_status),
        .retry_cnt     (retry_cnt),
        .fault         (fault),
        .seq_state     (seq_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic en, input logic rr, input logic raw, input logic ls,
                                input int cyc, input logic [2:0] st, input logic pma, input logic lc,
                                input logic loc, input logic [1:0] rt, input logic f);
        vec_t v;
        v.en  = en;
        v.rr  = rr;
        v.raw = raw;
        v.ls  = ls;
        v.cyc = cyc;
        v.exp = {st, pma, lc, loc, rt, f};
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {seq_state, pma_reset, link_control, loc_rcv_status, retry_cnt, fault};
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got st=%0d pma=%b lc=%b loc=%b retry=%0d fault=%b, expected st=%0d pma=%b lc=%b loc=%b retry=%0d fault=%b",
                     name, act[8:6], act[5], act[4], act[3], act[2:1], act[0],
                     exp[8:6], exp[5], exp[4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    initial begin
        //   en rr raw ls  cycles  st pma lc loc rt f
        add(1, 0, 1, 1,    0,   0, 1, 1, 0, 0, 0);  // reset state
        add(1, 0, 1, 1,   15,   0, 1, 1, 0, 0, 0);  // 16th reset-hold cycle
        add(1, 0, 1, 1,    1,   2, 0, 0, 0, 0, 0);  // enter QUALIFY
        add(1, 0, 1, 1,   63,   2, 0, 0, 0, 0, 0);  // 64th qualify cycle
        add(1, 0, 1, 1,    1,   3, 0, 0, 1, 0, 0);  // LINK_UP on cycle 81
        add(1, 0, 0, 1,    1,   2, 0, 0, 0, 0, 0);  // raw drops -> QUALIFY
        add(1, 0, 1, 1,   63,   2, 0, 0, 0, 0, 0);  // count reaches 63
        add(1, 0, 0, 1,    1,   2, 0, 0, 0, 0, 0);  // one-cycle glitch
        add(1, 0, 1, 1,   63,   2, 0, 0, 0, 0, 0);  // not yet requalified
        add(1, 0, 1, 1,    1,   3, 0, 0, 1, 0, 0);  // 64 cycles after glitch
        add(1, 1, 1, 1,    1,   0, 1, 1, 0, 0, 0);  // restart from LINK_UP
        add(1, 0, 1, 1,   15,   0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 1,    1,   2, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 4095,   2, 0, 0, 0, 0, 0);  // last cycle before timeout
        add(1, 0, 0, 1,    1,   0, 1, 1, 0, 1, 0);  // timeout 1
        add(1, 0, 1, 1,   16,   2, 0, 0, 0, 1, 0);
        add(1, 0, 1, 1,   64,   3, 0, 0, 1, 1, 0);  // link up, status FAIL keeps retry
        add(1, 1, 1, 1,    1,   0, 1, 1, 0, 1, 0);  // restart keeps retry_cnt
        add(1, 0, 1, 1,   16,   2, 0, 0, 0, 1, 0);
        add(1, 0, 1, 1,   64,   3, 0, 0, 1, 1, 0);
        add(1, 0, 1, 0,    1,   3, 0, 0, 1, 0, 0);  // status OK clears retry
        add(1, 0, 0, 1,    1,   2, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 4096,   0, 1, 1, 0, 1, 0);  // timeout 1
        add(1, 0, 0, 1,   16,   2, 0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 4096,   0, 1, 1, 0, 2, 0);  // timeout 2
        add(1, 0, 0, 1,   16,   2, 0, 0, 0, 2, 0);
        add(1, 0, 0, 1, 4095,   2, 0, 0, 0, 2, 0);
        add(1, 0, 0, 1,    1,   4, 0, 1, 0, 3, 1);  // timeout 3 -> FAULT
        add(1, 0, 0, 1,   10,   4, 0, 1, 0, 3, 1);  // FAULT is sticky
        add(1, 1, 0, 1,    1,   0, 1, 1, 0, 3, 1);  // restart keeps fault
        add(1, 0, 0, 1,   16,   2, 0, 0, 0, 3, 1);
        add(1, 0, 0, 1, 4096,   4, 0, 1, 0, 3, 1);  // saturated retry -> FAULT again
        add(0, 0, 0, 1,    1,   1, 0, 1, 0, 0, 0);  // disable clears fault/retry
        add(1, 0, 0, 1,    1,   2, 0, 0, 0, 0, 0);  // re-enable -> QUALIFY
        add(1, 0, 1, 1,    5,   2, 0, 0, 0, 0, 0);  // mid-QUALIFY

        reset = 1'b1;
        repeat (3) @(negedge clk);
        mgmt_enable = vecs[0].en;
        rcv_raw     = vecs[0].raw;
        link_status = vecs[0].ls;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            mgmt_enable  = vecs[i].en;
            mgmt_restart = vecs[i].rr;
            rcv_raw      = vecs[i].raw;
            link_status  = vecs[i].ls;
            repeat (vecs[i].cyc) @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        mgmt_restart = 1'b0;

        // Asynchronous reset mid-QUALIFY: outputs must change before any clock edge
        #2 reset = 1'b1;
        #1 check("async_reset", {3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0});

        // Reset hold with management disabled exits to DISABLED only at the end
        @(negedge clk);
        mgmt_enable = 1'b0;
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("hold_en0", {3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0});
        @(negedge clk);
        check("hold_to_disabled", {3'd1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/link_seq_147.md
Name: link_seq_147

Overview:
- Sequencing controller for the Clause 147 link monitor.
- Drives the monitor's pma_reset and link_control inputs.
- Qualifies (debounces) the raw PMA receive status into the monitor's loc_rcv_status input.
- Retries link bring-up with a bounded retry count, and reports a fault to management when retries are exhausted.
- Sits between the management register interface and the link monitor state diagram.

Parameters:
- RESET_CYCLES, 16: cycles pma_reset is held asserted per reset pulse.
- QUAL_CYCLES, 64: consecutive cycles rcv_raw must be 1 before loc_rcv_status asserts.
- LINK_TIMEOUT, 4096: maximum cycles spent in QUALIFY before a retry.
- MAX_RETRIES, 3: number of timeouts tolerated before declaring a fault.
- TIMER_W, 13: width of the shared cycle timer. Must hold max(RESET_CYCLES, QUAL_CYCLES, LINK_TIMEOUT).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- mgmt_enable  in  1  1 = management requests the link enabled.
- mgmt_restart  in  1  single-cycle synchronous request to restart bring-up.
- rcv_raw  in  1  unfiltered PMA receiver-locked indication.
- link_status  in  1  from the link monitor; OK = 0, FAIL = 1.
- pma_reset  out  1  reset to the PMA and link monitor.
- link_control  out  1  ENABLE = 0, DISABLE = 1.
- loc_rcv_status  out  1  qualified receive status.
- retry_cnt  out  2  timeouts since the last good link; saturates at MAX_RETRIES.
- fault  out  1  set when retries are exhausted.
- seq_state  out  3  current state encoding, for debug and the bench.

Behaviour:
- Reset asserted (asynchronous) forces:
  - state = RESET_HOLD, timer = 0, retry_cnt = 0;
  - pma_reset = 1, link_control = DISABLE, loc_rcv_status = 0, fault = 0.
- All outputs are registered and decoded from the current state.
- State change latency is 1 clk from the qualifying input edge.
- States and encodings: RESET_HOLD = 0, DISABLED = 1, QUALIFY = 2, LINK_UP = 3, FAULT = 4.
- Transition priority, applied every cycle, highest first:
  1. mgmt_restart → RESET_HOLD, timer = 0. Does not clear retry_cnt or fault.
  2. mgmt_enable = 0 while not in RESET_HOLD → DISABLED. Clears fault and retry_cnt.
  3. The state-specific rules below.
- RESET_HOLD:
  - pma_reset = 1, link_control = DISABLE.
  - timer counts up; when timer = RESET_CYCLES-1: go to QUALIFY if mgmt_enable = 1, else DISABLED.
  - In RESET_HOLD, mgmt_enable = 0 only affects this exit decision.
- DISABLED:
  - pma_reset = 0, link_control = DISABLE, loc_rcv_status = 0.
  - mgmt_enable = 1 → QUALIFY, timer = 0.
- QUALIFY:
  - link_control = ENABLE, loc_rcv_status = 0.
  - timer counts cycles in state. A separate stability counter counts consecutive cycles with rcv_raw = 1 and clears on rcv_raw = 0.
  - stability counter reaches QUAL_CYCLES → LINK_UP. loc_rcv_status = 1 from the first LINK_UP cycle.
  - timer reaches LINK_TIMEOUT-1 first → retry_cnt++.
    - If the new retry_cnt = MAX_RETRIES → FAULT.
    - Otherwise → RESET_HOLD.
  - If both conditions hit in the same cycle, qualification wins.
- LINK_UP:
  - link_control = ENABLE, loc_rcv_status = 1.
  - link_status = OK → retry_cnt cleared to 0.
  - rcv_raw = 0 → QUALIFY next cycle: loc_rcv_status = 0, timer and stability counter cleared. No debounce on the falling side.
- FAULT:
  - fault = 1, link_control = DISABLE, pma_reset = 0.
  - Left only via priority rule 1 or 2.
- Counters: unsigned and saturating; they never wrap. The stability counter is sized to ceil(log2(QUAL_CYCLES+1)).
- Outputs are glitch-free: no combinational paths from inputs to outputs.

Decomposition:
- Shared include file holds:
  - encodings OK/NOT_OK, OK/FAIL, ENABLE/DISABLE, matching those already used by the link monitor;
  - the five seq_state encodings.
- One natural sub-module, rcv_qual_147: consecutive-ones debouncer for rcv_raw.
  - Parameter QUAL_CYCLES.
  - Ports: clk, reset, clr, din, qualified.

Test Plan:
- Reset release with mgmt_enable = 1, rcv_raw = 1 held → pma_reset = 1 for exactly 16 cycles; QUALIFY for 64 cycles; loc_rcv_status = 1 on cycle 81; seq_state = 3.
- rcv_raw toggles 0 for one cycle at qualify count 63 → counter restarts; loc_rcv_status rises 64 cycles after the glitch ends.
- rcv_raw held 0 with mgmt_enable = 1 → three timeouts of 4096 cycles; retry_cnt goes 1, 2, 3; FAULT entered after the third; fault = 1, link_control = 1.
- In LINK_UP, rcv_raw drops to 0 → next cycle loc_rcv_status = 0, seq_state = 2.
- mgmt_enable deasserted in FAULT → DISABLED next cycle; fault = 0, retry_cnt = 0.
- Reset asserted mid-QUALIFY → outputs take reset values immediately without waiting for clk.
- mgmt_restart pulse in LINK_UP → 16-cycle pma_reset pulse; retry_cnt unchanged.
